// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Quotient reported for a zero divisor; sliced down to the operand width.
    localparam logic [63:0] DIV_BY_ZERO_Q = '1;

    // Counter width able to hold the iteration count WIDTH itself.
    function automatic int div_count_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// (WIDTH+1)-bit subtractor a - b: 4-bit carry-lookahead slices plus a 1-bit top stage.
module cla_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           cout
);

    localparam int SLICES = WIDTH / 4;

    logic [WIDTH:0]  b_n;
    logic [SLICES:0] c;

    // Two's-complement subtract: invert b and inject a carry of one.
    assign b_n  = ~b;
    assign c[0] = 1'b1;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;

        assign g     = a[4*s +: 4] & b_n[4*s +: 4];
        assign p     = a[4*s +: 4] ^ b_n[4*s +: 4];
        assign cc[0] = c[s];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);

        assign diff[4*s +: 4] = p ^ cc[3:0];
        assign c[s+1]         = cc[4];
    end

    assign diff[WIDTH] = a[WIDTH] ^ b_n[WIDTH] ^ c[SLICES];
    assign cout        = (a[WIDTH] & b_n[WIDTH]) | ((a[WIDTH] ^ b_n[WIDTH]) & c[SLICES]);

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_count_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   s_hi;
    logic [WIDTH-1:0] s_lo;
    logic [WIDTH:0]   t_diff;
    logic             t_cout;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] qr_next;

    // Upper and lower halves of {A, Q} shifted left by one.
    assign s_hi = (a_q << 1) | {{WIDTH{1'b0}}, qr_q[WIDTH-1]};
    assign s_lo = {qr_q[WIDTH-2:0], 1'b0};

    cla_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a    (s_hi),
        .b    ({1'b0, m_q}),
        .diff (t_diff),
        .cout (t_cout)
    );

    // A carry out means no borrow: keep the difference and set the quotient bit.
    assign a_next  = t_cout ? t_diff : s_hi;
    assign qr_next = {s_lo[WIDTH-1:1], t_cout};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        qr_d        = qr_q;
        m_d         = m_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = DIV_BY_ZERO_Q[WIDTH-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        a_d     = '0;
                        qr_d    = dividend;
                        m_d     = divisor;
                        count_d = CNT_W'(WIDTH);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                a_d     = a_next;
                qr_d    = qr_next;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    quotient_d  = qr_next;
                    remainder_d = a_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            qr_q        <= '0;
            m_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            qr_q        <= qr_d;
            m_q         <= m_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against an arithmetic reference model.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference model: plain integer division, all-ones quotient for a zero divisor.
    function automatic void ref_div(input int a, input int b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output int lat);
        if (b == 0) begin
            q = W'((1 << W) - 1); r = W'(a); z = 1'b1; lat = 1;
        end else begin
            q = W'(a / b); r = W'(a % b); z = 1'b0; lat = W + 1;
        end
    endfunction

    // Drives one operation from a falling edge with the DUT idle; returns at the
    // falling edge after the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output int busy_n, output logic idle_after);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_n++;
        q = quotient; r = remainder; z = div_by_zero;
        @(negedge clk);
        idle_after = !busy && !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int a_tab[4] = '{200, 255, 255, 5};
        int b_tab[4] = '{7, 1, 255, 9};
        logic [W-1:0] q, r, eq, er;
        logic z, ez, idle;
        int lat, elat, bn;
        for (int i = 0; i < 4; i++) begin
            run_op(W'(a_tab[i]), W'(b_tab[i]), q, r, z, lat, bn, idle);
            ref_div(a_tab[i], b_tab[i], eq, er, ez, elat);
            checks++; if (q !== eq) begin errors++; $display("FAIL basic_q %0d/%0d got %0d want %0d", a_tab[i], b_tab[i], q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL basic_r %0d/%0d got %0d want %0d", a_tab[i], b_tab[i], r, er); end
            checks++; if (z !== ez) begin errors++; $display("FAIL basic_dbz %0d/%0d got %b want %b", a_tab[i], b_tab[i], z, ez); end
            checks++; if (lat != elat) begin errors++; $display("FAIL basic_latency %0d/%0d got %0d want %0d", a_tab[i], b_tab[i], lat, elat); end
            checks++; if (bn != W + 1) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bn, W + 1); end
            checks++; if (idle !== 1'b1) begin errors++; $display("FAIL basic_idle_after got %b want 1", idle); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic z, idle;
        int lat, bn;
        run_op(8'd100, 8'd0, q, r, z, lat, bn, idle);
        checks++; if (q !== 8'd255) begin errors++; $display("FAIL dbz_q got %0d want 255", q); end
        checks++; if (r !== 8'd100) begin errors++; $display("FAIL dbz_r got %0d want 100", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", z); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL dbz_idle_after got %b want 1", idle); end
        run_op(8'd100, 8'd10, q, r, z, lat, bn, idle);
        checks++; if (q !== 8'd10) begin errors++; $display("FAIL after_dbz_q got %0d want 10", q); end
        checks++; if (r !== 8'd0) begin errors++; $display("FAIL after_dbz_r got %0d want 0", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL after_dbz_flag got %b want 0", z); end
    endtask

    task automatic test_ignore_inputs();
        int ndone = 0;
        logic [W-1:0] gq = '0, gr = '0;
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++; gq = quotient; gr = remainder; start = 1'b0;
            end else if (busy) begin
                start = 1'($urandom); dividend = W'($urandom); divisor = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (gq !== 8'd28) begin errors++; $display("FAIL ignore_q got %0d want 28", gq); end
        checks++; if (gr !== 8'd4) begin errors++; $display("FAIL ignore_r got %0d want 4", gr); end
        checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL ignore_hold_q got %0d want 28", quotient); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic z, idle;
        int lat, bn, spurious = 0;
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (quotient !== '0) begin errors++; $display("FAIL midrst_q got %0d want 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL midrst_r got %0d want 0", remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", spurious); end
        run_op(8'd77, 8'd5, q, r, z, lat, bn, idle);
        checks++; if (q !== 8'd15) begin errors++; $display("FAIL midrst_fresh_q got %0d want 15", q); end
        checks++; if (r !== 8'd2) begin errors++; $display("FAIL midrst_fresh_r got %0d want 2", r); end
    endtask

    task automatic test_random();
        logic [W-1:0] q, r, eq, er;
        logic z, ez, idle;
        int a, b, lat, elat, bn, bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (i % 10 == 0) b = 0;
            if (i % 10 == 1) a = 0;
            if (i % 10 == 2) b = int'($urandom_range(1, 4));
            run_op(W'(a), W'(b), q, r, z, lat, bn, idle);
            ref_div(a, b, eq, er, ez, elat);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat != elat || idle !== 1'b1) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random %0d/%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                             a, b, q, r, z, lat, eq, er, ez, elat);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$], exp_r[$];
        logic [W-1:0] eq, er;
        logic ez;
        int a, b, elat, ndone = 0, last = -1;
        start = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done) begin
                if (exp_q.size() > 0) begin
                    eq = exp_q.pop_front(); er = exp_r.pop_front();
                    checks++; if (quotient !== eq || remainder !== er) begin errors++;
                        $display("FAIL b2b_result got %0d r%0d want %0d r%0d", quotient, remainder, eq, er); end
                end
                if (last >= 0) begin
                    checks++; if (cyc - last != W + 2) begin errors++;
                        $display("FAIL b2b_interval got %0d want %0d", cyc - last, W + 2); end
                end
                last = cyc; ndone++;
            end
            if (!busy) begin
                a = int'($urandom_range(0, 255)); b = int'($urandom_range(1, 255));
                dividend = W'(a); divisor = W'(b);
                ref_div(a, b, eq, er, ez, elat);
                exp_q.push_back(eq); exp_r.push_back(er);
            end
            if (ndone == 5) break;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (ndone != 5) begin errors++; $display("FAIL b2b_done_count got %0d want 5", ndone); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_inputs();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
